// File: rtl/ds18b20_pkg.sv
// rtl/ds18b20_pkg.sv - shared PHY command codes, DS18B20 opcodes and sequencer states
package ds18b20_pkg;

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_INIT  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_READ  = 2'd3;

    localparam logic [7:0] ROM_SKIP   = 8'hCC;
    localparam logic [7:0] FN_CONVERT = 8'h44;
    localparam logic [7:0] FN_RDSCR   = 8'hBE;

    localparam int TMR_W = 26;

    typedef enum logic [3:0] {
        S_IDLE, S_RST1, S_SKIP1, S_CONV, S_WAITC,
        S_RST2, S_SKIP2, S_RDSP, S_READ, S_DONE, S_ERR
    } state_t;

endpackage

// File: rtl/ds18b20_tmr.sv
// rtl/ds18b20_tmr.sv - loadable down-counter that parks at zero and flags it
module ds18b20_tmr
    import ds18b20_pkg::*;
#(
    parameter logic [TMR_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_value,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RESET_VAL;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ds18b20_seq.sv
// rtl/ds18b20_seq.sv - DS18B20 convert/read transaction sequencer driving the 1-Wire PHY
// DS18B20_AUTO_SAMPLE_EN adds a free-running trigger every PERIOD_CYCLES.
module ds18b20_seq
    import ds18b20_pkg::*;
#(
    parameter int CONV_CYCLES    = 37500000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int PERIOD_CYCLES  = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [1:0]  cmd,
    output logic [7:0]  data,
    input  logic [2:0]  cmd_ok,
    input  logic        end_init,
    input  logic        end_bit,
    input  logic [15:0] rec_data,
    output logic [15:0] temp_raw,
    output logic        temp_valid,
    output logic        busy,
    output logic        err_nopres,
    output logic        err_timeout
);

    // The timer is loaded during a state's first cycle, so it starts one count short.
    localparam logic [TMR_W-1:0] CONV_LOAD = TMR_W'(CONV_CYCLES - 2);
    localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 2);

    state_t      r_state;
    logic [1:0]  r_cmd;
    logic [7:0]  r_data;
    logic [15:0] r_temp;
    logic        r_temp_valid;
    logic        r_busy;
    logic        r_err_nopres;
    logic        r_err_timeout;
    logic        r_tmr_load;

    logic             w_start;
    logic             w_unused;
    logic             w_tmr_zero;
    logic             w_expired;
    logic             w_done;
    logic             w_watch;
    logic [TMR_W-1:0] w_tmr_value;

`ifdef DS18B20_AUTO_SAMPLE_EN
    logic w_per_zero;

    ds18b20_tmr #(
        .RESET_VAL (TMR_W'(PERIOD_CYCLES - 1))
    ) u_period (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_per_zero),
        .i_value (TMR_W'(PERIOD_CYCLES - 1)),
        .o_zero  (w_per_zero)
    );

    assign w_start  = start | w_per_zero;
    assign w_unused = end_bit;
`else
    assign w_start  = start;
    assign w_unused = end_bit | (PERIOD_CYCLES == 0);
`endif

    // Conversion wait and watchdog never overlap, so one counter serves both.
    assign w_tmr_value = (r_state == S_WAITC) ? CONV_LOAD : TO_LOAD;

    ds18b20_tmr u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (r_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    assign w_expired = w_tmr_zero & ~r_tmr_load;
    assign w_watch   = r_state inside {S_RST1, S_SKIP1, S_CONV, S_RST2, S_SKIP2, S_RDSP, S_READ};

    always_comb begin
        w_done = 1'b0;
        case (r_state)
            S_RST1, S_RST2:                   w_done = end_init;
            S_SKIP1, S_CONV, S_SKIP2, S_RDSP: w_done = cmd_ok[1];
            S_WAITC:                          w_done = w_expired;
            S_READ:                           w_done = cmd_ok[2];
            default:                          w_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cmd         <= CMD_NOP;
            r_data        <= 8'h00;
            r_temp        <= 16'h0000;
            r_temp_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_err_nopres  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tmr_load    <= 1'b0;
        end else begin
            r_cmd        <= CMD_NOP;
            r_temp_valid <= 1'b0;
            r_tmr_load   <= 1'b0;
            if (w_watch && !w_done && w_expired) begin
                r_state       <= S_ERR;
                r_err_timeout <= 1'b1;
            end else begin
                if (w_done) r_tmr_load <= 1'b1;
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_state       <= S_RST1;
                        r_cmd         <= CMD_INIT;
                        r_data        <= 8'h00;
                        r_busy        <= 1'b1;
                        r_err_nopres  <= 1'b0;
                        r_err_timeout <= 1'b0;
                        r_tmr_load    <= 1'b1;
                    end
                    S_RST1, S_RST2: if (w_done) begin
                        if (cmd_ok[0]) begin
                            r_state <= (r_state == S_RST1) ? S_SKIP1 : S_SKIP2;
                            r_cmd   <= CMD_WRITE;
                            r_data  <= ROM_SKIP;
                        end else begin
                            r_state      <= S_ERR;
                            r_err_nopres <= 1'b1;
                        end
                    end
                    S_SKIP1: if (w_done) begin
                        r_state <= S_CONV;
                        r_cmd   <= CMD_WRITE;
                        r_data  <= FN_CONVERT;
                    end
                    S_CONV: if (w_done) r_state <= S_WAITC;
                    S_WAITC: if (w_done) begin
                        r_state <= S_RST2;
                        r_cmd   <= CMD_INIT;
                        r_data  <= 8'h00;
                    end
                    S_SKIP2: if (w_done) begin
                        r_state <= S_RDSP;
                        r_cmd   <= CMD_WRITE;
                        r_data  <= FN_RDSCR;
                    end
                    S_RDSP: if (w_done) begin
                        r_state <= S_READ;
                        r_cmd   <= CMD_READ;
                        r_data  <= 8'h00;
                    end
                    // The byte-0 end_bit needs no action; only the 16-bit completion counts.
                    S_READ: if (w_done) begin
                        r_temp       <= rec_data;
                        r_temp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                    S_DONE, S_ERR: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd         = r_cmd;
    assign data        = r_data;
    assign temp_raw    = r_temp;
    assign temp_valid  = r_temp_valid;
    assign busy        = r_busy;
    assign err_nopres  = r_err_nopres;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ds18b20_seq.sv
// tb/tb_ds18b20_seq.sv - directed bench for ds18b20_seq with a fixed-latency PHY model
module tb_ds18b20_seq;

    localparam int D_INIT = 10;
    localparam int D_WR   = 12;
    localparam int D_RD   = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  cmd_ok = 3'b000;
    logic        end_init = 1'b0;
    logic        end_bit = 1'b0;
    logic [15:0] rec_data = 16'h0000;
    logic [1:0]  cmd;
    logic [7:0]  data;
    logic [15:0] temp_raw;
    logic        temp_valid;
    logic        busy;
    logic        err_nopres;
    logic        err_timeout;

    ds18b20_seq #(
        .CONV_CYCLES    (100),
        .TIMEOUT_CYCLES (5000),
        .PERIOD_CYCLES  (20000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmd         (cmd),
        .data        (data),
        .cmd_ok      (cmd_ok),
        .end_init    (end_init),
        .end_bit     (end_bit),
        .rec_data    (rec_data),
        .temp_raw    (temp_raw),
        .temp_valid  (temp_valid),
        .busy        (busy),
        .err_nopres  (err_nopres),
        .err_timeout (err_timeout)
    );

    initial forever #10 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    bit          m_pres = 1'b1;
    bit          m_hang = 1'b0;
    logic [15:0] m_rdata = 16'h0000;
    int          m_kind = 0;
    int          m_cnt = 0;
    logic [7:0]  m_wdata = 8'h00;
    logic [1:0]  log_cmd[$];
    logic [7:0]  log_dat[$];
    int          log_cyc[$];
    int conv_entry = -1, conv_done = -1, init2 = -1, to_cyc = -1;
    int tv_cyc = -1, busy_fall = -1, n_tv = 0;
    int n_b2b = 0, n_overlap = 0, n_dchg = 0;
    logic prev_nz = 1'b0, prev_to = 1'b0, prev_busy = 1'b0;

    // PHY model and output monitor, both evaluated on the falling edge.
    initial forever begin
        @(negedge clk);
        end_init = 1'b0;
        end_bit  = 1'b0;
        cmd_ok   = 3'b000;
        if (!rst_n) begin
            m_kind = 0; prev_nz = 1'b0; prev_to = 1'b0; prev_busy = 1'b0;
        end else begin
            if (temp_valid) begin n_tv++; tv_cyc = cyc; end
            if (prev_busy && !busy) busy_fall = cyc;
            if (err_timeout && !prev_to) to_cyc = cyc;
            if (m_kind == 2 && data !== m_wdata) n_dchg++;
            if (m_kind != 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    case (m_kind)
                        1: begin end_init = 1'b1; cmd_ok[0] = m_pres; m_kind = 0; end
                        2: begin
                            cmd_ok[1] = 1'b1; m_kind = 0;
                            if (m_wdata == 8'h44) conv_done = cyc;
                        end
                        3: begin end_bit = 1'b1; m_kind = 4; m_cnt = D_RD; end
                        default: begin
                            end_bit = 1'b1; cmd_ok[2] = 1'b1; rec_data = m_rdata; m_kind = 0;
                        end
                    endcase
                end
            end
            if (cmd != 2'd0) begin
                if (prev_nz) n_b2b++;
                if (m_kind != 0) n_overlap++;
                log_cmd.push_back(cmd);
                log_dat.push_back(data);
                log_cyc.push_back(cyc);
                if (cmd == 2'd1 && conv_done >= 0 && init2 < 0) init2 = cyc;
                if (cmd == 2'd2 && data == 8'h44) conv_entry = cyc;
                m_cnt   = (cmd == 2'd1) ? D_INIT : (cmd == 2'd2) ? D_WR : D_RD;
                m_kind  = int'(cmd);
                m_wdata = data;
                if (cmd == 2'd2 && data == 8'h44 && m_hang) m_kind = 0;
            end
            prev_nz   = (cmd != 2'd0);
            prev_to   = err_timeout;
            prev_busy = busy;
        end
    end

    task automatic clear_log();
        log_cmd.delete(); log_dat.delete(); log_cyc.delete();
        conv_entry = -1; conv_done = -1; init2 = -1; to_cyc = -1;
        tv_cyc = -1; busy_fall = -1; n_tv = 0;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1;
        repeat (n) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 20000) begin @(negedge clk); k++; end
        check(tag, k < 20000, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int bound, input string tag);
        int k = 0;
        while (log_cmd.size() < n && k < bound) begin @(negedge clk); k++; end
        check(tag, k < bound, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"}, cmd, 2'd0);
        check({tag, "_data"}, data, 8'h00);
        check({tag, "_temp"}, temp_raw, 16'h0000);
        check({tag, "_tvalid"}, temp_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_nopres"}, err_nopres, 1'b0);
        check({tag, "_timeout"}, err_timeout, 1'b0);
    endtask

    logic [1:0] exp_cmd[7] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [7:0] exp_dat[7] = '{8'h00, 8'hCC, 8'h44, 8'h00, 8'hCC, 8'hBE, 8'h00};

    initial begin
        int n_init;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
`ifdef DS18B20_AUTO_SAMPLE_EN
        begin
            int rel;
            rel = cyc;
            wait_log(1, 25000, "auto_first_wait");
            check("auto_first_at", (log_cyc[0] - rel) >= 19998 && (log_cyc[0] - rel) <= 20002, 1'b1);
            wait_log(8, 25000, "auto_second_wait");
            check("auto_second_cmd", log_cmd[7], 2'd1);
            check("auto_period", log_cyc[7] - log_cyc[0], 20000);
            check("auto_b2b", n_b2b, 0);
        end
`else
        // Nominal transaction
        clear_log(); m_rdata = 16'h0191;
        pulse_start(1);
        wait_idle("nom_done");
        check("nom_ncmd", log_cmd.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < log_cmd.size()) begin
                check($sformatf("nom_cmd%0d", i), log_cmd[i], exp_cmd[i]);
                if (exp_cmd[i] == 2'd2) check($sformatf("nom_dat%0d", i), log_dat[i], exp_dat[i]);
            end
        end
        check("nom_wait_gap", init2 - conv_done, 101);
        check("nom_temp", temp_raw, 16'h0191);
        check("nom_ntv", n_tv, 1);
        check("nom_busy_fall", busy_fall - tv_cyc, 1);
        check("nom_errs", {err_nopres, err_timeout}, 2'b00);

        // No presence on the first reset slot
        clear_log(); m_pres = 1'b0;
        pulse_start(1);
        wait_idle("nopres_done");
        check("nopres_flag", err_nopres, 1'b1);
        check("nopres_ncmd", log_cmd.size(), 1);
        check("nopres_busy", busy, 1'b0);
        check("nopres_temp", temp_raw, 16'h0191);
        check("nopres_ntv", n_tv, 0);

        // Convert write never completes
        clear_log(); m_pres = 1'b1; m_hang = 1'b1;
        pulse_start(1);
        wait_idle("to_done");
        check("to_flag", err_timeout, 1'b1);
        check("to_nopres_cleared", err_nopres, 1'b0);
        check("to_latency", to_cyc - conv_entry, 5000);
        check("to_ncmd", log_cmd.size(), 3);
        check("to_temp", temp_raw, 16'h0191);

        // Negative temperature; start clears the sticky error
        clear_log(); m_hang = 1'b0; m_rdata = 16'hFF5E;
        pulse_start(1);
        check("neg_busy", busy, 1'b1);
        check("neg_err_cleared", err_timeout, 1'b0);
        wait_idle("neg_done");
        check("neg_temp", temp_raw, 16'hFF5E);
        check("neg_ntv", n_tv, 1);

        // Held start plus a re-pulse during the conversion wait
        clear_log(); m_rdata = 16'h0123;
        pulse_start(3);
        wait_log(3, 2000, "hold_reach_conv");
        repeat (40) @(negedge clk);
        pulse_start(1);
        wait_idle("hold_done");
        repeat (30) @(negedge clk);
        n_init = 0;
        foreach (log_cmd[i]) if (log_cmd[i] == 2'd1) n_init++;
        check("hold_ninit", n_init, 2);
        check("hold_ncmd", log_cmd.size(), 7);
        check("hold_temp", temp_raw, 16'h0123);
        check("hold_b2b", n_b2b, 0);

        // Reset in the middle of the scratchpad read
        clear_log(); m_rdata = 16'h1234;
        pulse_start(1);
        wait_log(7, 2000, "rstr_reach_read");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstr");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log(); m_rdata = 16'h0550;
        pulse_start(1);
        wait_idle("rstr_after_done");
        check("rstr_after_ncmd", log_cmd.size(), 7);
        check("rstr_after_temp", temp_raw, 16'h0550);
        check("rstr_after_ntv", n_tv, 1);
        check("overlap", n_overlap, 0);
        check("data_hold", n_dchg, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
